// File: rtl/lab2_proc_xm_resolve.sv
// X-to-M boundary stage: resolves conditional branches, issues a one-cycle
// redirect to fetch/decode, and registers surviving X-stage state into M.
module lab2_proc_xm_resolve #(
    parameter int unsigned p_nbits      = 32,
    parameter int unsigned p_nregs_bits = 5
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    val_X,
    input  logic [p_nbits-1:0]      alu_out_X,
    input  logic                    ops_eq_X,
    input  logic                    op0_zero_X,
    input  logic                    op0_neg_X,
    input  logic [2:0]              br_type_X,
    input  logic [p_nbits-1:0]      br_target_X,
    input  logic [p_nbits-1:0]      st_data_X,
    input  logic [1:0]              dmem_type_X,
    input  logic                    rf_wen_X,
    input  logic [p_nregs_bits-1:0] rf_waddr_X,
    input  logic                    stall_M,

    output logic                    stall_X,
    output logic                    br_taken_X,
    output logic [p_nbits-1:0]      br_redirect_pc,
    output logic                    val_M,
    output logic [p_nbits-1:0]      result_M,
    output logic [p_nbits-1:0]      st_data_M,
    output logic [1:0]              dmem_type_M,
    output logic                    rf_wen_M,
    output logic [p_nregs_bits-1:0] rf_waddr_M,
    output logic [31:0]             br_count
);

    localparam int unsigned CNT_W = 32;

    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLEZ = 3'd3;
    localparam logic [2:0] BR_BGTZ = 3'd4;
    localparam logic [2:0] BR_BLTZ = 3'd5;
    localparam logic [2:0] BR_BGEZ = 3'd6;

    typedef struct packed {
        logic [p_nbits-1:0]      result;
        logic [p_nbits-1:0]      st_data;
        logic [1:0]              dmem_type;
        logic                    rf_wen;
        logic [p_nregs_bits-1:0] rf_waddr;
    } xm_payload_t;

    logic        br_cond;
    logic        val_q;
    xm_payload_t pay_q;
    xm_payload_t pay_d;
    logic [CNT_W-1:0] count_q;

    // Branch condition from the ALU comparison flags; none/reserved never take
    always_comb begin
        br_cond = 1'b0;
        case (br_type_X)
            BR_BEQ:  br_cond = ops_eq_X;
            BR_BNE:  br_cond = !ops_eq_X;
            BR_BLEZ: br_cond = op0_zero_X | op0_neg_X;
            BR_BGTZ: br_cond = !op0_zero_X & !op0_neg_X;
            BR_BLTZ: br_cond = op0_neg_X;
            BR_BGEZ: br_cond = !op0_neg_X;
            default: br_cond = 1'b0;
        endcase
    end

    // Redirect only in the cycle the branch actually advances, so one pulse per branch
    assign br_taken_X     = val_X & !stall_M & br_cond;
    assign br_redirect_pc = br_target_X;
    assign stall_X        = val_X & stall_M;

    assign pay_d = '{result:    alu_out_X,
                     st_data:   st_data_X,
                     dmem_type: dmem_type_X,
                     rf_wen:    rf_wen_X,
                     rf_waddr:  rf_waddr_X};

    // X/M pipeline register: hold under stall, payload captured even for bubbles
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= 1'b0;
            pay_q <= '0;
        end else if (!stall_M) begin
            val_q <= val_X;
            pay_q <= pay_d;
        end
    end

    // Taken-branch counter; wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (br_taken_X) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Bubbles never write the register file or touch memory
    assign val_M       = val_q;
    assign result_M    = pay_q.result;
    assign st_data_M   = pay_q.st_data;
    assign dmem_type_M = val_q ? pay_q.dmem_type : 2'd0;
    assign rf_wen_M    = val_q & pay_q.rf_wen;
    assign rf_waddr_M  = pay_q.rf_waddr;
    assign br_count    = count_q;

endmodule
